fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage controller for the rv64 pipeline. It owns the fetch PC and issues instruction-memory requests. It applies control-flow redirects with a fixed priority (trap > mret > branch) and discards stale responses. It presents fetched instructions to the decode register through the pipeline's valid/allow_in handshake. It sits between the instruction memory port and regD, and replaces the free-running PC increment with a sequenced request/response flow.

## Interface
- WIDTH, 64, PC/address width
- RESET_PC, 64'h80000000, fetch address after reset
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- regD_allow_in  in  1  decode register can accept this cycle
- fs_to_ds_valid  out  1  fs_pc/fs_inst hold a valid instruction
- fs_pc  out  WIDTH  PC of presented instruction
- fs_inst  out  32  presented instruction
- br_taken  in  1  execute-stage branch/jump redirect
- br_target  in  WIDTH  branch target
- mret_valid  in  1  mret redirect
- mepc  in  WIDTH  mret target
- trap_valid  in  1  trap redirect
- trap_vector  in  WIDTH  trap target
- imem_req  out  1  request valid
- imem_addr  out  WIDTH  request address (= pc)
- imem_gnt  in  1  request accepted this cycle (req && gnt)
- imem_rvalid  in  1  response valid, at least 1 cycle after gnt
- imem_rdata  in  32  response instruction

## Operation
- State registers:
  - pc (WIDTH)
  - state ∈ {REQ, WAIT, DISCARD}
  - output slot: fs_valid, fs_pc, fs_inst
- At most one outstanding memory request.
- imem_req = (state==REQ) && (!fs_valid || regD_allow_in). The slot is therefore guaranteed free when the response returns.
- imem_addr = pc at all times. It may change while a request is unacknowledged only because of a redirect.
- Slot consume: fs_valid && regD_allow_in clears fs_valid unless a response fills it the same cycle.
- Redirect: redirect = trap_valid | mret_valid | br_taken. The target is chosen by priority trap_vector > mepc > br_target, with bits [1:0] forced to 0.
- Transitions without redirect:
  - REQ: req && gnt → WAIT, otherwise stay.
  - WAIT: rvalid → slot loaded {fs_pc=pc, fs_inst=imem_rdata, fs_valid=1}, pc ← pc+4 (wraps mod 2^WIDTH), → REQ.
  - DISCARD: rvalid → response dropped, → REQ.
- Transitions with redirect (any state):
  - pc ← target.
  - fs_valid ← 0, including when regD_allow_in is high: the slot holds a wrong-path instruction.
  - REQ with no gnt → REQ; the new address appears next cycle.
  - REQ with req && gnt → DISCARD (the granted request is stale).
  - WAIT with no rvalid → DISCARD.
  - WAIT with rvalid → response dropped, pc not incremented, → REQ.
  - DISCARD with no rvalid → stays DISCARD.
  - DISCARD with rvalid → REQ.
- imem_rvalid in state REQ is ignored. This covers memory that is not reset together with this block.

## Timing
- Reset (rst high at an edge) sets the following, mid-operation included:
  - pc=RESET_PC, state=REQ, fs_valid=0, fs_pc=0, fs_inst=0.
  - Any in-flight transfer is abandoned.
- First cycle after reset: imem_req=1, imem_addr=RESET_PC.
- Best-case throughput is 1 instruction per 2 cycles:
  - cycle N: req+gnt
  - cycle N+1: rvalid
  - cycle N+2: fs_to_ds_valid=1 and imem_req=1 for pc+4
- Redirect penalty: the target is requested the cycle after the redirect, or 1 cycle after the pending rvalid if the state is DISCARD.
- Redirect inputs are single-cycle pulses sampled at the clock edge. Simultaneous redirects resolve by priority only; no redirect is queued.
- fs_to_ds_valid is registered. imem_req depends combinationally on regD_allow_in.

## Test plan
- Reset then 0-wait memory (gnt=1, rvalid 1 cycle later), regD_allow_in=1:
  - fs_pc sequence is 80000000, 80000004, 80000008, one new value every 2 cycles.
  - fs_inst matches memory.
- regD_allow_in=0 for 5 cycles with slot full:
  - imem_req=0 and fs_pc/fs_inst stay stable.
  - After release, the next req goes out in the same cycle as the consume.
- br_taken (target 80000102) in WAIT without rvalid:
  - The next rvalid is dropped and fs_valid stays 0.
  - The next imem_addr=80000100.
- trap_valid (80001000), mret_valid (80002000) and br_taken (80003000) in the same cycle:
  - pc=80001000.
  - A valid slot is flushed (fs_to_ds_valid=0 the next cycle).
- Redirect in REQ with gnt in the same cycle:
  - The state goes through DISCARD.
  - The response is dropped, then the target is requested.
- rst asserted during WAIT, then a late rvalid arrives in REQ:
  - The response is ignored and imem_addr=80000000.
  - fs_to_ds_valid=0 until the fresh response arrives.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch PC owner: sequenced imem requests, prioritized redirects, decode slot
module fetch_ctrl #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(64'h8000_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regD_allow_in,
    output logic             fs_to_ds_valid,
    output logic [WIDTH-1:0] fs_pc,
    output logic [31:0]      fs_inst,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             mret_valid,
    input  logic [WIDTH-1:0] mepc,
    input  logic             trap_valid,
    input  logic [WIDTH-1:0] trap_vector,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata
);

    localparam logic [1:0] ST_REQ     = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] pc;
    logic             fs_valid;
    logic             redirect;
    logic [WIDTH-1:0] redirect_raw;
    logic [WIDTH-1:0] redirect_tgt;
    logic             handshake;

    assign redirect     = trap_valid | mret_valid | br_taken;
    assign redirect_raw = trap_valid ? trap_vector : (mret_valid ? mepc : br_target);
    assign redirect_tgt = redirect_raw & ~WIDTH'(3);

    // Only request when the slot will be free by the time the response lands.
    assign imem_req       = (state == ST_REQ) && (!fs_valid || regD_allow_in);
    assign imem_addr      = pc;
    assign handshake      = imem_req && imem_gnt;
    assign fs_to_ds_valid = fs_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            state    <= ST_REQ;
            fs_valid <= 1'b0;
            fs_pc    <= '0;
            fs_inst  <= '0;
        end else begin
            if (fs_valid && regD_allow_in) begin
                fs_valid <= 1'b0;
            end
            if (redirect) begin
                pc       <= redirect_tgt;
                fs_valid <= 1'b0;
                case (state)
                    ST_REQ:     if (handshake) state <= ST_DISCARD;
                    ST_WAIT:    state <= imem_rvalid ? ST_REQ : ST_DISCARD;
                    ST_DISCARD: if (imem_rvalid) state <= ST_REQ;
                    default:    state <= ST_REQ;
                endcase
            end else begin
                case (state)
                    ST_REQ: begin
                        if (handshake) state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            fs_valid <= 1'b1;
                            fs_pc    <= pc;
                            fs_inst  <= imem_rdata;
                            pc       <= pc + WIDTH'(4);
                            state    <= ST_REQ;
                        end
                    end
                    ST_DISCARD: begin
                        if (imem_rvalid) state <= ST_REQ;
                    end
                    default: state <= ST_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          NCYC     = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        regD_allow_in;
    logic        fs_to_ds_valid;
    logic [63:0] fs_pc;
    logic [31:0] fs_inst;
    logic        br_taken, mret_valid, trap_valid;
    logic [63:0] br_target, mepc, trap_vector;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt, imem_rvalid;
    logic [31:0] imem_rdata;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .regD_allow_in(regD_allow_in),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
        .br_taken(br_taken), .br_target(br_target),
        .mret_valid(mret_valid), .mepc(mepc),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [95:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ {a[17:2], ~a[17:2]};
    endfunction

    function automatic logic [63:0] rand_target();
        return {32'h0, 32'h8000_0000 | 32'($urandom_range(0, 32'hFFFF))};
    endfunction

    // Monitor: pops one expected instruction per new presentation to decode.
    initial begin
        logic        pv = 1'b0, pcons = 1'b0, pflush = 1'b1;
        logic [63:0] ppc = '0;
        logic [31:0] pinst = '0;
        logic [95:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0; pflush = 1'b1;
                continue;
            end
            if (pflush) chk("flush_valid", 64'(fs_to_ds_valid), 64'd0);
            if (fs_to_ds_valid) begin
                if (pv && !pcons) begin
                    chk("stall_pc", fs_pc, ppc);
                    chk("stall_inst", 64'(fs_inst), 64'(pinst));
                end else if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_inst: got pc %h inst %h expected none", fs_pc, fs_inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("fs_pc", fs_pc, e[95:32]);
                    chk("fs_inst", 64'(fs_inst), 64'(e[31:0]));
                end
            end
            pv     = fs_to_ds_valid;
            pcons  = regD_allow_in;
            pflush = br_taken | mret_valid | trap_valid;
            ppc    = fs_pc;
            pinst  = fs_inst;
        end
    end

    // Driver and reference model: epoch-tagged requests, a fetch PC and a slot flag.
    initial begin
        logic        outstanding = 1'b0, orphan = 1'b0, m_slot = 1'b0;
        logic        did_reset = 1'b0, rst_now, ideal, drain, redir, accept;
        logic [63:0] o_addr = '0, m_pc = RESET_PC, tgt;
        int          o_epoch = 0, o_delay = 0, m_epoch = 0, ideal_start = 0;

        rst = 1'b1; regD_allow_in = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; br_taken = 1'b0; mret_valid = 1'b0; trap_valid = 1'b0;
        br_target = '0; mepc = '0; trap_vector = '0;
        repeat (3) @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk); #1;
            rst_now = (cyc >= 1500) && !did_reset && outstanding;
            if (rst_now) did_reset = 1'b1;
            ideal = (cyc - ideal_start) < 40;
            drain = cyc >= NCYC - 20;
            rst = rst_now;

            regD_allow_in = (ideal || drain) ? 1'b1 : ((cyc % 200) < 8 ? 1'b0 : ($urandom % 4 != 0));
            imem_gnt = (orphan || drain || rst_now) ? 1'b0 : (ideal ? 1'b1 : ($urandom % 3 != 0));
            imem_rdata = $urandom;
            imem_rvalid = 1'b0;
            if (orphan) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hdead_beef;
            end else if (outstanding && o_delay == 0 && !rst_now) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(o_addr);
            end
            trap_valid = !(ideal || drain) && ($urandom % 12 == 0);
            mret_valid = !(ideal || drain) && ($urandom % 12 == 0);
            br_taken   = !(ideal || drain) && ($urandom % 10 == 0);
            trap_vector = rand_target();
            mepc        = rand_target();
            br_target   = rand_target();

            @(negedge clk);
            if (rst_now) begin
                orphan = outstanding; outstanding = 1'b0;
                m_pc = RESET_PC; m_slot = 1'b0; m_epoch++;
                exp_q.delete();
                ideal_start = cyc + 2;
                continue;
            end
            if (cyc == 0) begin
                chk("reset_valid", 64'(fs_to_ds_valid), 64'd0);
                chk("reset_fs_pc", fs_pc, 64'd0);
                chk("reset_fs_inst", 64'(fs_inst), 64'd0);
                chk("reset_addr", imem_addr, RESET_PC);
            end

            redir = trap_valid | mret_valid | br_taken;
            tgt   = trap_valid ? trap_vector : (mret_valid ? mepc : br_target);
            tgt[1:0] = 2'b00;

            chk("imem_req", 64'(imem_req), 64'(!outstanding && (!m_slot || regD_allow_in)));
            if (imem_req) chk("imem_addr", imem_addr, m_pc);

            accept = 1'b0;
            if (orphan && imem_rvalid) orphan = 1'b0;
            else if (imem_rvalid && outstanding) begin
                outstanding = 1'b0;
                if (o_epoch == m_epoch && !redir) begin
                    exp_q.push_back({o_addr, mem_word(o_addr)});
                    m_pc   = m_pc + 64'd4;
                    accept = 1'b1;
                end
            end else if (outstanding) o_delay--;

            if (imem_req && imem_gnt && !outstanding) begin
                outstanding = 1'b1;
                o_addr  = m_pc;
                o_epoch = m_epoch;
                o_delay = ideal ? 0 : int'($urandom % 3);
            end
            if (redir) begin
                m_epoch++;
                m_pc = tgt;
            end
            m_slot = accept ? 1'b1 : (redir ? 1'b0 : (m_slot && !regD_allow_in));
        end

        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
